pcs_40g_tx_sched: RTL and testbench

Transmit scheduler between the MAC and the 40G PCS transmit path. It buffers 4-lane XGMII words from the MAC in a small FIFO, presents one word per cycle to the PCS, and advances only when the PCS raises ready (gearbox-full and alignment-marker stall cycles hold it). When no MAC data is buffered it inserts idle words between packets; if the FIFO runs dry mid-packet it emits error words until the packet terminates.

---
 rtl/pcs_40g_pkg.sv | 57 +++++
 rtl/pcs_fifo.sv | 62 ++++++
 rtl/pcs_40g_tx_sched.sv | 218 +++++++++++++++++++++
 tb/tb_pcs_40g_tx_sched.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcs_40g_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pcs_40g_pkg
//  Description : Shared constants, state/delimiter enums, idle/error lane
//                flag patterns and the last-delimiter helper used by the
//                40G PCS transmit scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package pcs_40g_pkg;

    localparam int PCS_LANE_N    = 4;
    localparam int PCS_DATA_W    = 64;
    localparam int PCS_KEEP_W    = $clog2(PCS_DATA_W);
    // Widest lane count the delimiter helper can scan.
    localparam int PCS_MAX_LANES = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PKT   = 2'd1,
        DRAIN = 2'd2
    } tx_state_t;

    typedef enum logic [1:0] {
        DELIM_NONE  = 2'd0,
        DELIM_START = 2'd1,
        DELIM_TERM  = 2'd2
    } delim_t;

    // Per-lane flag pattern; replicated across all lanes to form a word.
    typedef struct packed {
        logic ctrl;
        logic idle;
        logic start;
        logic term;
        logic err;
    } lane_flags_t;

    localparam lane_flags_t IDLE_WORD = '{ctrl: 1'b1, idle: 1'b1, start: 1'b0, term: 1'b0, err: 1'b0};
    localparam lane_flags_t ERR_WORD  = '{ctrl: 1'b1, idle: 1'b0, start: 1'b0, term: 1'b0, err: 1'b1};

    // Delimiter in the highest-indexed lane carrying start or term.
    // Vectors are zero-extended by the caller; higher lanes overwrite lower.
    function automatic delim_t last_delim(
        input logic [PCS_MAX_LANES-1:0] start_v,
        input logic [PCS_MAX_LANES-1:0] term_v
    );
        delim_t d;
        d = DELIM_NONE;
        for (int i = 0; i < PCS_MAX_LANES; i++) begin
            if (start_v[i]) d = DELIM_START;
            if (term_v[i])  d = DELIM_TERM;
        end
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pcs_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : pcs_fifo
//  Description : Generic synchronous FIFO with first-word-fall-through read
//                port and occupancy output. DEPTH must be a power of two.
//  Revision    : 1.0 - initial release
// ============================================================================
module pcs_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
)(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_wr_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_rd_data,
    output logic [$clog2(DEPTH+1)-1:0] o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);
    localparam logic [LW-1:0] c_FULL = LW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             w_do_push;
    logic             w_do_pop;

    // Overflow/underflow guards keep the pointers coherent even if misused.
    assign w_do_push = i_push & (r_level != c_FULL);
    assign w_do_pop  = i_pop  & (r_level != '0);

    // Storage write; contents need no reset since level gates visibility.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wr_data;
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_level   = r_level;

endmodule
`default_nettype wire

// File: rtl/pcs_40g_tx_sched.sv
`default_nettype none
// ============================================================================
//  Module      : pcs_40g_tx_sched
//  Description : MAC-to-PCS transmit scheduler. Buffers XGMII words, holds a
//                packet start until enough words are queued, inserts idle
//                words between packets and error words on mid-packet underrun.
//  Revision    : 1.0 - initial release
// ============================================================================
module pcs_40g_tx_sched
    import pcs_40g_pkg::*;
#(
    parameter int LANE_N       = PCS_LANE_N,
    parameter int DATA_W       = PCS_DATA_W,
    parameter int KEEP_W       = $clog2(DATA_W),
    parameter int XGMII_DATA_W = LANE_N*DATA_W,
    parameter int XGMII_KEEP_W = LANE_N*KEEP_W,
    parameter int DEPTH        = 4,
    parameter int START_TH     = 2
)(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       mac_valid_i,
    output logic                       mac_ready_o,
    input  logic [LANE_N-1:0]          ctrl_v_i,
    input  logic [LANE_N-1:0]          idle_v_i,
    input  logic [LANE_N-1:0]          start_v_i,
    input  logic [LANE_N-1:0]          term_v_i,
    input  logic [LANE_N-1:0]          err_v_i,
    input  logic [XGMII_DATA_W-1:0]    data_i,
    input  logic [XGMII_KEEP_W-1:0]    keep_i,
    input  logic                       pcs_ready_i,
    output logic [LANE_N-1:0]          ctrl_v_o,
    output logic [LANE_N-1:0]          idle_v_o,
    output logic [LANE_N-1:0]          start_v_o,
    output logic [LANE_N-1:0]          term_v_o,
    output logic [LANE_N-1:0]          err_v_o,
    output logic [XGMII_DATA_W-1:0]    data_o,
    output logic [XGMII_KEEP_W-1:0]    keep_o,
    output logic                       underrun_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o
);

    localparam int FLAG_W  = 5*LANE_N;
    localparam int ENTRY_W = FLAG_W + XGMII_DATA_W + XGMII_KEEP_W;
    localparam int LVL_W   = $clog2(DEPTH+1);

    localparam logic [LVL_W-1:0] c_DEPTH    = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] c_START_TH = LVL_W'(START_TH);

    // Flag order throughout: {ctrl, idle, start, term, err}, each LANE_N wide.
    localparam logic [FLAG_W-1:0] c_IDLE_FLAGS = {{LANE_N{IDLE_WORD.ctrl}},  {LANE_N{IDLE_WORD.idle}},
                                                  {LANE_N{IDLE_WORD.start}}, {LANE_N{IDLE_WORD.term}},
                                                  {LANE_N{IDLE_WORD.err}}};
    localparam logic [FLAG_W-1:0] c_ERR_FLAGS  = {{LANE_N{ERR_WORD.ctrl}},   {LANE_N{ERR_WORD.idle}},
                                                  {LANE_N{ERR_WORD.start}},  {LANE_N{ERR_WORD.term}},
                                                  {LANE_N{ERR_WORD.err}}};

    localparam logic [1:0] c_SEL_IDLE = 2'd0;
    localparam logic [1:0] c_SEL_ERR  = 2'd1;
    localparam logic [1:0] c_SEL_HEAD = 2'd2;

    logic                     w_push;
    logic                     w_pop;
    logic [ENTRY_W-1:0]       w_wr_entry;
    logic [ENTRY_W-1:0]       w_head;
    logic [FLAG_W-1:0]        w_h_flags;
    logic [XGMII_DATA_W-1:0]  w_h_data;
    logic [XGMII_KEEP_W-1:0]  w_h_keep;
    logic [LANE_N-1:0]        w_h_start;
    logic [LANE_N-1:0]        w_h_term;
    logic [PCS_MAX_LANES-1:0] w_start_ext;
    logic [PCS_MAX_LANES-1:0] w_term_ext;
    delim_t                   w_head_delim;
    logic [LVL_W-1:0]         w_level;
    logic [LVL_W-1:0]         w_level_next;
    logic                     w_empty;
    logic [1:0]               w_sel;
    logic                     w_underrun_set;
    tx_state_t                w_state_next;

    tx_state_t                r_state;
    logic [FLAG_W-1:0]        r_flags;
    logic [XGMII_DATA_W-1:0]  r_data;
    logic [XGMII_KEEP_W-1:0]  r_keep;
    logic                     r_underrun;
    logic                     r_mac_ready;

    assign w_push     = mac_valid_i & r_mac_ready;
    assign w_wr_entry = {ctrl_v_i, idle_v_i, start_v_i, term_v_i, err_v_i, data_i, keep_i};

    pcs_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (reset),
        .i_push    (w_push),
        .i_wr_data (w_wr_entry),
        .i_pop     (w_pop),
        .o_rd_data (w_head),
        .o_level   (w_level)
    );

    assign {w_h_flags, w_h_data, w_h_keep} = w_head;
    assign w_h_start = w_h_flags[3*LANE_N-1 -: LANE_N];
    assign w_h_term  = w_h_flags[2*LANE_N-1 -: LANE_N];
    assign w_empty   = (w_level == '0);

    // Widen head delimiters to the helper's fixed scan width.
    always_comb begin
        w_start_ext             = '0;
        w_term_ext              = '0;
        w_start_ext[LANE_N-1:0] = w_h_start;
        w_term_ext[LANE_N-1:0]  = w_h_term;
    end

    assign w_head_delim = last_delim(w_start_ext, w_term_ext);

    // Load-cycle decision: what to present next, whether to pop, next state.
    always_comb begin
        w_pop          = 1'b0;
        w_sel          = c_SEL_IDLE;
        w_underrun_set = 1'b0;
        w_state_next   = r_state;
        if (pcs_ready_i) begin
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        if (w_h_start == '0) begin
                            w_pop = 1'b1;
                            w_sel = c_SEL_HEAD;
                        end else if (w_level >= c_START_TH) begin
                            // Enough buffered to ride out short MAC gaps.
                            w_pop = 1'b1;
                            w_sel = c_SEL_HEAD;
                            if (w_head_delim == DELIM_START) w_state_next = PKT;
                        end
                    end
                end
                PKT: begin
                    if (w_empty) begin
                        w_sel          = c_SEL_ERR;
                        w_underrun_set = 1'b1;
                        w_state_next   = DRAIN;
                    end else begin
                        w_pop = 1'b1;
                        w_sel = c_SEL_HEAD;
                        if (w_head_delim == DELIM_TERM) w_state_next = IDLE;
                    end
                end
                DRAIN: begin
                    // Discard the rest of the broken packet behind error words.
                    w_sel = c_SEL_ERR;
                    if (!w_empty) begin
                        w_pop = 1'b1;
                        if (w_head_delim == DELIM_TERM) w_state_next = IDLE;
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    // Occupancy after this edge, used to decide next-cycle MAC ready.
    always_comb begin
        w_level_next = w_level;
        if (w_push && !w_pop)      w_level_next = w_level + LVL_W'(1);
        else if (!w_push && w_pop) w_level_next = w_level - LVL_W'(1);
    end

    // Scheduler state and registered PCS word; frozen while the PCS stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_flags    <= c_IDLE_FLAGS;
            r_data     <= '0;
            r_keep     <= '0;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= w_underrun_set;
            if (pcs_ready_i) begin
                r_state <= w_state_next;
                case (w_sel)
                    c_SEL_HEAD: begin
                        r_flags <= w_h_flags;
                        r_data  <= w_h_data;
                        r_keep  <= w_h_keep;
                    end
                    c_SEL_ERR: begin
                        r_flags <= c_ERR_FLAGS;
                        r_data  <= '0;
                        r_keep  <= '0;
                    end
                    default: begin
                        r_flags <= c_IDLE_FLAGS;
                        r_data  <= '0;
                        r_keep  <= '0;
                    end
                endcase
            end
        end
    end

    // MAC backpressure: ready whenever the FIFO will have a free slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_mac_ready <= 1'b0;
        else       r_mac_ready <= (w_level_next < c_DEPTH);
    end

    assign {ctrl_v_o, idle_v_o, start_v_o, term_v_o, err_v_o} = r_flags;
    assign data_o      = r_data;
    assign keep_o      = r_keep;
    assign underrun_o  = r_underrun;
    assign mac_ready_o = r_mac_ready;
    assign level_o     = w_level;

endmodule
`default_nettype wire

// File: tb/tb_pcs_40g_tx_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pcs_40g_tx_sched
//  Description : Self-checking bench for pcs_40g_tx_sched against a
//                queue-based reference model of the scheduling rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pcs_40g_tx_sched;

    localparam int LANE_N   = 4;
    localparam int DEPTH    = 4;
    localparam int START_TH = 2;

    localparam int MODE_IDLE  = 0;
    localparam int MODE_PKT   = 1;
    localparam int MODE_DRAIN = 2;
    localparam int D_NONE  = 0;
    localparam int D_START = 1;
    localparam int D_TERM  = 2;

    typedef struct packed {
        logic [3:0]   ctrl;
        logic [3:0]   idle;
        logic [3:0]   start;
        logic [3:0]   term;
        logic [3:0]   err;
        logic [255:0] data;
        logic [23:0]  keep;
    } word_t;

    logic         clk;
    logic         reset;
    logic         mac_valid;
    word_t        mac_word;
    logic         pcs_ready;
    logic         mac_ready_o;
    logic [3:0]   ctrl_v_o, idle_v_o, start_v_o, term_v_o, err_v_o;
    logic [255:0] data_o;
    logic [23:0]  keep_o;
    logic         underrun_o;
    logic [2:0]   level_o;

    int n_checks;
    int n_fail;

    // Reference model state
    word_t fifo_q[$];
    word_t mac_q[$];
    word_t m_out;
    logic  m_ready;
    logic  m_under;
    int    m_mode;

    pcs_40g_tx_sched #(
        .DEPTH    (DEPTH),
        .START_TH (START_TH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mac_valid_i (mac_valid),
        .mac_ready_o (mac_ready_o),
        .ctrl_v_i    (mac_word.ctrl),
        .idle_v_i    (mac_word.idle),
        .start_v_i   (mac_word.start),
        .term_v_i    (mac_word.term),
        .err_v_i     (mac_word.err),
        .data_i      (mac_word.data),
        .keep_i      (mac_word.keep),
        .pcs_ready_i (pcs_ready),
        .ctrl_v_o    (ctrl_v_o),
        .idle_v_o    (idle_v_o),
        .start_v_o   (start_v_o),
        .term_v_o    (term_v_o),
        .err_v_o     (err_v_o),
        .data_o      (data_o),
        .keep_o      (keep_o),
        .underrun_o  (underrun_o),
        .level_o     (level_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic word_t idle_word();
        word_t w = '0;
        w.ctrl = '1;
        w.idle = '1;
        return w;
    endfunction

    function automatic word_t err_word();
        word_t w = '0;
        w.ctrl = '1;
        w.err  = '1;
        return w;
    endfunction

    function automatic word_t rand_payload();
        word_t w = '0;
        for (int i = 0; i < 8; i++) w.data[i*32 +: 32] = $urandom();
        w.keep = 24'($urandom() & 32'h00FF_FFFF);
        return w;
    endfunction

    function automatic word_t start_word();
        word_t w = rand_payload();
        w.ctrl[0]  = 1'b1;
        w.start[0] = 1'b1;
        return w;
    endfunction

    function automatic word_t term_word(input int lane);
        word_t w = rand_payload();
        for (int l = lane; l < LANE_N; l++) w.ctrl[l] = 1'b1;
        for (int l = lane + 1; l < LANE_N; l++) w.idle[l] = 1'b1;
        w.term[lane] = 1'b1;
        return w;
    endfunction

    // Term in lane 1 then a fresh start in lane 3 of the same word.
    function automatic word_t term_start_word();
        word_t w = rand_payload();
        w.ctrl[1]  = 1'b1;
        w.term[1]  = 1'b1;
        w.ctrl[2]  = 1'b1;
        w.idle[2]  = 1'b1;
        w.ctrl[3]  = 1'b1;
        w.start[3] = 1'b1;
        return w;
    endfunction

    // Delimiter of the highest lane carrying one, found scanning downward.
    function automatic int last_del(input word_t w);
        for (int l = LANE_N - 1; l >= 0; l--) begin
            if (w.term[l])  return D_TERM;
            if (w.start[l]) return D_START;
        end
        return D_NONE;
    endfunction

    task automatic gen_packet();
        word_t w;
        int    n;
        int    lane;
        repeat ($urandom_range(0, 2)) mac_q.push_back(idle_word());
        mac_q.push_back(start_word());
        n = int'($urandom_range(0, 4));
        for (int i = 0; i < n; i++) begin
            w = rand_payload();
            case ($urandom_range(0, 9))
                0: begin
                    lane = int'($urandom_range(0, 3));
                    w.ctrl[lane] = 1'b1;
                    w.err[lane]  = 1'b1;
                end
                1: w = term_start_word();
                default: ;
            endcase
            mac_q.push_back(w);
        end
        mac_q.push_back(term_word(int'($urandom_range(0, 3))));
    endtask

    task automatic model_reset();
        fifo_q.delete();
        m_mode  = MODE_IDLE;
        m_out   = idle_word();
        m_ready = 1'b0;
        m_under = 1'b0;
    endtask

    // One clock edge of scheduling behaviour; pops happen before the push.
    task automatic model_step();
        logic  push;
        word_t w;
        if (reset) begin
            model_reset();
            return;
        end
        push    = mac_valid && m_ready;
        m_under = 1'b0;
        if (pcs_ready) begin
            case (m_mode)
                MODE_IDLE: begin
                    if (fifo_q.size() == 0) begin
                        m_out = idle_word();
                    end else if (fifo_q[0].start == 4'b0) begin
                        m_out = fifo_q.pop_front();
                    end else if (fifo_q.size() >= START_TH) begin
                        w     = fifo_q.pop_front();
                        m_out = w;
                        if (last_del(w) == D_START) m_mode = MODE_PKT;
                    end else begin
                        m_out = idle_word();
                    end
                end
                MODE_PKT: begin
                    if (fifo_q.size() == 0) begin
                        m_out   = err_word();
                        m_under = 1'b1;
                        m_mode  = MODE_DRAIN;
                    end else begin
                        w     = fifo_q.pop_front();
                        m_out = w;
                        if (last_del(w) == D_TERM) m_mode = MODE_IDLE;
                    end
                end
                default: begin
                    m_out = err_word();
                    if (fifo_q.size() != 0) begin
                        w = fifo_q.pop_front();
                        if (last_del(w) == D_TERM) m_mode = MODE_IDLE;
                    end
                end
            endcase
        end
        if (push) begin
            fifo_q.push_back(mac_word);
            w = mac_q.pop_front();
        end
        m_ready = (fifo_q.size() < DEPTH);
    endtask

    function automatic word_t observed();
        word_t w;
        w.ctrl  = ctrl_v_o;
        w.idle  = idle_v_o;
        w.start = start_v_o;
        w.term  = term_v_o;
        w.err   = err_v_o;
        w.data  = data_o;
        w.keep  = keep_o;
        return w;
    endfunction

    task automatic check_outputs();
        check_eq("out_word", 320'(observed()), 320'(m_out));
        check_eq("level",    320'(level_o), 320'(fifo_q.size()));
        check_eq("mac_ready", 320'(mac_ready_o), 320'(m_ready));
        check_eq("underrun", 320'(underrun_o), 320'(m_under));
    endtask

    task automatic drive(input int pv, input int pr);
        if (mac_q.size() > 0 && int'($urandom_range(0, 99)) < pv) begin
            mac_valid = 1'b1;
            mac_word  = mac_q[0];
        end else begin
            mac_valid = 1'b0;
            mac_word  = rand_payload();
        end
        pcs_ready = (int'($urandom_range(0, 99)) < pr);
    endtask

    task automatic cycle(input int pv, input int pr, input logic rst_v);
        @(negedge clk);
        check_outputs();
        reset = rst_v;
        drive(pv, pr);
        @(posedge clk);
        model_step();
    endtask

    // Assert reset between edges and confirm the outputs clear at once.
    task automatic reset_now();
        @(negedge clk);
        check_outputs();
        reset     = 1'b1;
        mac_valid = 1'b0;
        #1;
        check_eq("rst_out_word", 320'(observed()), 320'(idle_word()));
        check_eq("rst_level",    320'(level_o), 320'(0));
        check_eq("rst_mac_ready", 320'(mac_ready_o), 320'(0));
        check_eq("rst_underrun", 320'(underrun_o), 320'(0));
        mac_q.delete();
        @(posedge clk);
        model_step();
        repeat (2) cycle(0, 50, 1'b1);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        mac_valid = 1'b0;
        mac_word  = '0;
        pcs_ready = 1'b0;
        model_reset();

        repeat (3) cycle(0, 100, 1'b1);
        // No traffic: idle stream
        repeat (10) cycle(0, 100, 1'b0);

        // Short packet, start lane0 / term lane3
        mac_q.push_back(start_word());
        mac_q.push_back(rand_payload());
        mac_q.push_back(term_word(3));
        repeat (10) cycle(100, 100, 1'b0);

        // PCS stall mid-packet while the MAC keeps streaming
        mac_q.push_back(start_word());
        repeat (6) mac_q.push_back(rand_payload());
        mac_q.push_back(term_word(2));
        repeat (4) cycle(100, 100, 1'b0);
        repeat (5) cycle(100, 0, 1'b0);
        repeat (12) cycle(100, 100, 1'b0);

        // MAC stops after two words of a five-word packet
        mac_q.push_back(start_word());
        mac_q.push_back(rand_payload());
        repeat (7) cycle(100, 100, 1'b0);
        mac_q.push_back(rand_payload());
        mac_q.push_back(rand_payload());
        mac_q.push_back(term_word(1));
        repeat (8) cycle(100, 100, 1'b0);

        // Term lane1 + start lane3 inside a packet
        mac_q.push_back(start_word());
        mac_q.push_back(term_start_word());
        mac_q.push_back(rand_payload());
        mac_q.push_back(term_word(0));
        repeat (10) cycle(100, 100, 1'b0);

        // Reset with words buffered while in a packet
        mac_q.push_back(start_word());
        repeat (6) mac_q.push_back(rand_payload());
        mac_q.push_back(term_word(3));
        repeat (3) cycle(100, 100, 1'b0);
        cycle(100, 0, 1'b0);
        reset_now();
        repeat (5) cycle(0, 100, 1'b0);

        // Randomised traffic with varying MAC and PCS duty cycles
        for (int seg = 0; seg < 6; seg++) begin
            int pv;
            int pr;
            pv = (seg % 3 == 0) ? 100 : ((seg % 3 == 1) ? 85 : 60);
            pr = (seg < 2) ? 100 : ((seg < 4) ? 75 : 50);
            for (int c = 0; c < 500; c++) begin
                if (mac_q.size() < 8) gen_packet();
                cycle(pv, pr, 1'b0);
            end
            if (seg == 3) reset_now();
        end

        repeat (30) cycle(100, 100, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
